// File: rtl/pc_sequencer_pkg.sv
// Shared encodings and constants for the PC sequencer.
`default_nettype none

package pc_sequencer_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_JR   = 2'd2,
    SRC_J    = 2'd3
  } redir_src_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_WORD_SHIFT = 2;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_target_calc.sv
// pc_target_calc: combinational branch / jump / jr target generation.
`default_nettype none

module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [15:0] branch_imm,
  input  logic [31:0] branch_pc4,
  input  logic [31:0] pc_plus4,
  input  logic [25:0] jump_index,
  input  logic [31:0] jump_reg_addr,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [31:0] jr_target,
  output logic        jr_misaligned
);

  logic [31:0] branch_offset;

  // Word offset: sign-extend the immediate, then convert words to bytes.
  assign branch_offset = {{16{branch_imm[15]}}, branch_imm} << INSTR_WORD_SHIFT;
  assign branch_target = branch_pc4 + branch_offset;

  assign jump_target   = {pc_plus4[31:28], jump_index, {INSTR_WORD_SHIFT{1'b0}}};

  assign jr_target     = {jump_reg_addr[31:INSTR_WORD_SHIFT], {INSTR_WORD_SHIFT{1'b0}}};
  assign jr_misaligned = |jump_reg_addr[INSTR_WORD_SHIFT-1:0];

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// Program counter sequencer: redirect arbitration, flush timing, fetch valid.
// Optional BRANCH_STATS_EN adds saturating TakenCount / FlushCount outputs.
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchImm,
  input  logic [31:0] BranchPC4,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegAddr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        FetchValid,
  output logic        AddrError
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] TakenCount,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t      state, state_n;
  redir_src_t  src;
  logic [1:0]  flush_cnt, flush_cnt_n;
  logic [31:0] pc_n;
  logic [31:0] target;
  logic        redirect;
  logic        started;
  logic        addr_err_n;

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        jr_misaligned;

  assign PCPlus4 = PC + 32'd4;

  pc_target_calc u_target_calc (
    .branch_imm    (BranchImm),
    .branch_pc4    (BranchPC4),
    .pc_plus4      (PCPlus4),
    .jump_index    (JumpIndex),
    .jump_reg_addr (JumpRegAddr),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .jr_misaligned (jr_misaligned)
  );

  // Jumps arriving during FLUSH belong to already-killed instructions.
  always_comb begin
    src = SRC_NONE;
    if (BranchTaken)
      src = SRC_BR;
    else if (state == ST_RUN && JumpReg)
      src = SRC_JR;
    else if (state == ST_RUN && Jump)
      src = SRC_J;
  end

  always_comb begin
    target = PCPlus4;
    unique case (src)
      SRC_BR:   target = branch_target;
      SRC_JR:   target = jr_target;
      SRC_J:    target = jump_target;
      default:  target = PCPlus4;
    endcase
  end

  assign redirect   = (src != SRC_NONE);
  assign addr_err_n = (src == SRC_JR) && jr_misaligned;
  assign Flush      = redirect || (state == ST_FLUSH);
  assign FetchValid = started && !Flush;

  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    pc_n        = PC;
    if (redirect) begin
      pc_n = target;
      if (FLUSH_CYCLES > 1) begin
        state_n     = ST_FLUSH;
        flush_cnt_n = FLUSH_RELOAD;
      end else begin
        state_n     = ST_RUN;
        flush_cnt_n = 2'd0;
      end
    end else begin
      if (!Stall)
        pc_n = PCPlus4;
      if (state == ST_FLUSH) begin
        if (flush_cnt <= 2'd1) begin
          state_n     = ST_RUN;
          flush_cnt_n = 2'd0;
        end else begin
          flush_cnt_n = flush_cnt - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_RUN;
      flush_cnt <= 2'd0;
      PC        <= RESET_PC;
      started   <= 1'b0;
      AddrError <= 1'b0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
      PC        <= pc_n;
      started   <= 1'b1;
      AddrError <= addr_err_n;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      TakenCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (redirect && TakenCount != 32'hFFFF_FFFF)
        TakenCount <= TakenCount + 32'd1;
      if (Flush && FlushCount != 32'hFFFF_FFFF)
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a behavioural model.
// Checks the BRANCH_STATS_EN counters when that macro is defined.
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 3;

  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, Jump, JumpReg;
  logic [15:0] BranchImm;
  logic [31:0] BranchPC4, JumpRegAddr;
  logic [25:0] JumpIndex;
  logic [31:0] PC, PCPlus4;
  logic        Flush, FetchValid, AddrError;
`ifdef BRANCH_STATS_EN
  logic [31:0] TakenCount, FlushCount;
`endif

  pc_sequencer #(
    .RESET_PC     (RESET_PC),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchImm   (BranchImm),
    .BranchPC4   (BranchPC4),
    .Jump        (Jump),
    .JumpIndex   (JumpIndex),
    .JumpReg     (JumpReg),
    .JumpRegAddr (JumpRegAddr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .Flush       (Flush),
    .FetchValid  (FetchValid),
    .AddrError   (AddrError)
`ifdef BRANCH_STATS_EN
    ,
    .TakenCount  (TakenCount),
    .FlushCount  (FlushCount)
`endif
  );

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_flush_left;
  bit          m_started;
  bit          m_aerr;
  logic [31:0] m_taken;
  logic [31:0] m_flushes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc         = RESET_PC;
    m_flush_left = 0;
    m_started    = 0;
    m_aerr       = 0;
    m_taken      = 0;
    m_flushes    = 0;
  endtask

  task automatic idle_inputs();
    Stall       = 0;
    BranchTaken = 0;
    BranchImm   = 0;
    BranchPC4   = 0;
    Jump        = 0;
    JumpIndex   = 0;
    JumpReg     = 0;
    JumpRegAddr = 0;
  endtask

  // Inputs are set just after a falling edge; checks, clocks the model, returns after next falling edge.
  task automatic cycle();
    logic signed [31:0] off;
    logic [31:0] tgt;
    bit acc, is_jr, in_flush, exp_flush;
    #1;
    in_flush = (m_flush_left > 0);
    acc = 0; is_jr = 0; tgt = 0;
    off = $signed(BranchImm);
    if (BranchTaken) begin
      acc = 1; tgt = BranchPC4 + off * 4;
    end else if (!in_flush && JumpReg) begin
      acc = 1; is_jr = 1; tgt = JumpRegAddr & ~32'd3;
    end else if (!in_flush && Jump) begin
      acc = 1; tgt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, JumpIndex} * 4);
    end
    exp_flush = acc || in_flush;
    check("pc", PC, m_pc);
    check("pc_plus4", PCPlus4, m_pc + 32'd4);
    check("flush", {31'd0, Flush}, {31'd0, exp_flush});
    check("fetch_valid", {31'd0, FetchValid}, {31'd0, m_started && !exp_flush});
    check("addr_error", {31'd0, AddrError}, {31'd0, m_aerr});
`ifdef BRANCH_STATS_EN
    check("taken_count", TakenCount, m_taken);
    check("flush_count", FlushCount, m_flushes);
`endif
    @(posedge Clk);
    if (acc) begin
      m_pc = tgt;
      m_flush_left = FLUSH_CYCLES - 1;
      m_taken++;
    end else begin
      if (!Stall) m_pc = m_pc + 32'd4;
      if (in_flush) m_flush_left--;
    end
    m_aerr = is_jr && (JumpRegAddr % 4 != 0);
    if (exp_flush) m_flushes++;
    m_started = 1;
    @(negedge Clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    Reset = 1;
    #12;
    check("rst_pc", PC, RESET_PC);
    check("rst_flush", {31'd0, Flush}, 32'd0);
    check("rst_fetch_valid", {31'd0, FetchValid}, 32'd0);
    check("rst_addr_error", {31'd0, AddrError}, 32'd0);
    @(negedge Clk);
    Reset = 0;
    repeat (4) cycle();

    // Backward branch: 0x100 + (-2 words) = 0xF8
    BranchTaken = 1; BranchPC4 = 32'h100; BranchImm = 16'hFFFE;
    cycle();
    check("br_back_target", PC, 32'h0000_00F8);
    repeat (3) cycle();

    // Branch and jump together: branch wins
    BranchTaken = 1; BranchPC4 = 32'h100; BranchImm = 16'h0040;
    Jump = 1; JumpIndex = 26'h40;
    cycle();
    check("br_over_jump", PC, 32'h0000_0200);
    repeat (3) cycle();

    // Stall holds PC, then stalled misaligned jr still redirects
    repeat (3) begin Stall = 1; cycle(); end
    Stall = 1; JumpReg = 1; JumpRegAddr = 32'h0000_1003;
    cycle();
    check("jr_aligned_target", PC, 32'h0000_1000);
    check("jr_addr_error", {31'd0, AddrError}, 32'd1);
    repeat (4) cycle();

    // Back-to-back branches: second restarts the flush window
    BranchTaken = 1; BranchPC4 = 32'h400; BranchImm = 16'h0004;
    cycle();
    BranchTaken = 1; BranchPC4 = 32'h800; BranchImm = 16'h0000;
    cycle();
    check("br_second_target", PC, 32'h0000_0800);
    repeat (4) cycle();

    // Target wraps modulo 2^32
    BranchTaken = 1; BranchPC4 = 32'hFFFF_FFFC; BranchImm = 16'h0001;
    cycle();
    check("br_wrap", PC, 32'h0000_0000);
    repeat (3) cycle();

    // Async reset in the middle of a flush window
    BranchTaken = 1; BranchPC4 = 32'h40; BranchImm = 16'h0010;
    cycle();
    #2 Reset = 1;
    #1;
    check("mid_flush_rst_pc", PC, RESET_PC);
    check("mid_flush_rst_flush", {31'd0, Flush}, 32'd0);
    check("mid_flush_rst_fv", {31'd0, FetchValid}, 32'd0);
    @(negedge Clk);
    Reset = 0;
    model_reset();
    repeat (2) cycle();

    for (int i = 0; i < 400; i++) begin
      Stall       = ($urandom % 4) == 0;
      BranchTaken = ($urandom % 6) == 0;
      BranchImm   = 16'($urandom);
      BranchPC4   = $urandom;
      Jump        = ($urandom % 5) == 0;
      JumpIndex   = 26'($urandom);
      JumpReg     = ($urandom % 5) == 0;
      JumpRegAddr = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
